regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the pipelined core: NUM_RD combinational read ports, NUM_WR synchronous write ports and a per-register busy scoreboard for in-flight producers.
- Same-cycle write-to-read bypass, so the decode stage sees data written in that cycle.
- Register 0 is hardwired to zero.
- After reset, a clear sequencer zeroes the array before the core is released.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_bypass_mux.sv | 41 ++++
 rtl/regfile_mp.sv | 140 ++++++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
//   rf_state_e : clear sequencer state (RF_CLEAR while zeroing, RF_RUN after)
//   XLEN_DEF   : default data width
//   NREGS_DEF  : default number of architectural registers
//   idx_w()    : index width for a given register count
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: read-port data select for one read port.
//   rd_idx     : register index addressed by this read port
//   entry      : current array contents at rd_idx
//   wr_en      : per-write-port enables (NUM_WR)
//   wr_idx     : flattened write indices, port p at [p*IDXW +: IDXW]
//   wr_data    : flattened write data, port p at [p*XLEN +: XLEN]
//   data       : selected read data (0 for index 0, else bypass or array)
//   bypass_hit : some write port targets rd_idx this cycle
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_WR = 2,
    localparam int IDXW  = idx_w(NREGS)
) (
    input  logic [IDXW-1:0]        rd_idx,
    input  logic [XLEN-1:0]        entry,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*IDXW-1:0] wr_idx,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]        data,
    output logic                   bypass_hit
);

    // Ascending scan: a later (higher) port overrides, so the highest
    // matching write port supplies the bypass data.
    always_comb begin
        data       = entry;
        bypass_hit = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_idx[p*IDXW +: IDXW] == rd_idx) && (rd_idx != '0)) begin
                data       = wr_data[p*XLEN +: XLEN];
                bypass_hit = 1'b1;
            end
        end
        if (rd_idx == '0)
            data = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with busy scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   ready      : clear sequence finished, file usable
//   wr_en/wr_idx/wr_data : NUM_WR synchronous write ports (flattened)
//   rd_idx/rd_data/rd_busy : NUM_RD combinational read ports with
//                            same-cycle write bypass
//   rsv_en/rsv_idx : mark a register busy for an in-flight producer
// Optional (macro REGFILE_PARITY_EN): per-entry even parity,
//   par_err    : NUM_RD parity mismatch on non-bypassed array reads
//   force_flip : {enable, idx} inverts the stored parity of idx
// Register 0 always reads 0 and is never busy.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int IDXW  = idx_w(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ready,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*IDXW-1:0] wr_idx,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic [NUM_RD*IDXW-1:0] rd_idx,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
`ifdef REGFILE_PARITY_EN
    output logic [NUM_RD-1:0]      par_err,
    input  logic [IDXW:0]          force_flip,
`endif
    input  logic                   rsv_en,
    input  logic [IDXW-1:0]        rsv_idx
);

    rf_state_e                         state;
    logic [IDXW-1:0]                   clr_cnt;
    logic [NREGS-1:0][XLEN-1:0]        mem;
    logic [NREGS-1:0]                  busy;
    logic                              run;

    logic [NUM_WR-1:0][IDXW-1:0]       wr_idx_a;
    logic [NUM_WR-1:0][XLEN-1:0]       wr_data_a;
    logic [NUM_RD-1:0][IDXW-1:0]       rd_idx_a;

    assign wr_idx_a  = wr_idx;
    assign wr_data_a = wr_data;
    assign rd_idx_a  = rd_idx;

    assign run   = (state == RF_RUN);
    assign ready = run;

    // Sequencer and scoreboard. In RUN, reserve is applied after the
    // write loop so a same-cycle reserve of a written index leaves it busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
            busy    <= '0;
        end else if (state == RF_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == IDXW'(NREGS-1))
                state <= RF_RUN;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_idx_a[p] != '0))
                    busy[wr_idx_a[p]] <= 1'b0;
            end
            if (rsv_en && (rsv_idx != '0))
                busy[rsv_idx] <= 1'b1;
        end
    end

    // Data array: no reset, it is zeroed by the clear sequencer instead.
    // Ascending port order lets the highest port win on index collisions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == RF_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wr_idx_a[p] != '0))
                        mem[wr_idx_a[p]] <= wr_data_a[p];
                end
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [NREGS-1:0] par;

    // The flip acts on the currently stored bit; it is a fault-injection
    // hook and takes precedence over a same-cycle write of that entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == RF_CLEAR) begin
                par[clr_cnt] <= 1'b0;
            end else begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wr_idx_a[p] != '0))
                        par[wr_idx_a[p]] <= ^wr_data_a[p];
                end
            end
            if (force_flip[IDXW])
                par[force_flip[IDXW-1:0]] <= ~par[force_flip[IDXW-1:0]];
        end
    end
`endif

    for (genvar q = 0; q < NUM_RD; q++) begin : g_rd
        logic [XLEN-1:0] mux_data;
        logic            hit;

        regfile_bypass_mux #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .NUM_WR (NUM_WR)
        ) u_mux (
            .rd_idx     (rd_idx_a[q]),
            .entry      (mem[rd_idx_a[q]]),
            .wr_en      (wr_en),
            .wr_idx     (wr_idx),
            .wr_data    (wr_data),
            .data       (mux_data),
            .bypass_hit (hit)
        );

        // A bypassing write retires the producer, so the reader sees not-busy.
        assign rd_data[q*XLEN +: XLEN] = run ? mux_data : '0;
        assign rd_busy[q]              = run && !hit && busy[rd_idx_a[q]];

`ifdef REGFILE_PARITY_EN
        assign par_err[q] = run && !hit && (rd_idx_a[q] != '0) &&
                            ((^mem[rd_idx_a[q]]) != par[rd_idx_a[q]]);
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp (default params).
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN = 64;
    localparam int IW   = 5;

    logic            clk;
    logic            reset;
    logic            ready;
    logic [1:0]      wr_en;
    logic [2*IW-1:0] wr_idx;
    logic [127:0]    wr_data;
    logic [2*IW-1:0] rd_idx;
    logic [127:0]    rd_data;
    logic [1:0]      rd_busy;
    logic            rsv_en;
    logic [IW-1:0]   rsv_idx;
`ifdef REGFILE_PARITY_EN
    logic [1:0]      par_err;
    logic [IW:0]     force_flip;
`endif

    regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
`ifdef REGFILE_PARITY_EN
        .par_err    (par_err),
        .force_flip (force_flip),
`endif
        .rsv_en     (rsv_en),
        .rsv_idx    (rsv_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    we;
        logic [IW-1:0] wi0;
        logic [63:0]   wd0;
        logic [IW-1:0] wi1;
        logic [63:0]   wd1;
        logic          re;
        logic [IW-1:0] ri;
        logic [IW-1:0] r0;
        logic [IW-1:0] r1;
        logic [63:0]   e0;
        logic [63:0]   e1;
        logic [1:0]    eb;
    } vec_t;

    localparam int NV = 16;
    vec_t v [NV];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_idx  = '0;
        wr_data = '0;
        rd_idx  = '0;
        rsv_en  = 1'b0;
        rsv_idx = '0;
`ifdef REGFILE_PARITY_EN
        force_flip = '0;
`endif
    endtask

    // Counts cycles from the current negedge until ready rises, checking
    // that reads stay zero and not-busy throughout the clear.
    task automatic wait_ready(input string nm);
        int  n;
        bit  bad;
        n   = 0;
        bad = 0;
        while (!ready && n < 100) begin
            if (rd_data !== '0 || rd_busy !== '0) bad = 1;
            @(negedge clk);
            n++;
        end
        chk({nm, " clear_len"}, 64'(n), 64'd32);
        chk({nm, " clear_zero_reads"}, 64'(bad), 64'd0);
    endtask

    initial begin
        // RUN-mode vectors, applied back to back right after the first clear.
        v[0]  = '{2'b01, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd5, 5'd6, 64'hDEAD_BEEF_0000_0001, 64'd0, 2'b00};
        v[1]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd5, 5'd0, 64'hDEAD_BEEF_0000_0001, 64'd0, 2'b00};
        v[2]  = '{2'b11, 5'd7, 64'h11, 5'd7, 64'h22, 1'b0, 5'd0,
                  5'd7, 5'd5, 64'h22, 64'hDEAD_BEEF_0000_0001, 2'b00};
        v[3]  = '{2'b01, 5'd0, 64'hFF, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd0, 5'd7, 64'd0, 64'h22, 2'b00};
        v[4]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd0, 5'd7, 64'd0, 64'h22, 2'b00};
        v[5]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9,
                  5'd9, 5'd9, 64'd0, 64'd0, 2'b00};
        v[6]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd9, 5'd7, 64'd0, 64'h22, 2'b01};
        v[7]  = '{2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 1'b1, 5'd9,
                  5'd9, 5'd7, 64'h99, 64'h22, 2'b00};
        v[8]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd9, 5'd9, 64'h99, 64'h99, 2'b11};
        v[9]  = '{2'b10, 5'd0, 64'd0, 5'd9, 64'hAA, 1'b0, 5'd0,
                  5'd9, 5'd5, 64'hAA, 64'hDEAD_BEEF_0000_0001, 2'b00};
        v[10] = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd9, 5'd9, 64'hAA, 64'hAA, 2'b00};
        v[11] = '{2'b11, 5'd3, 64'h55, 5'd10, 64'h1234, 1'b0, 5'd0,
                  5'd10, 5'd3, 64'h1234, 64'h55, 2'b00};
        v[12] = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd0,
                  5'd0, 5'd3, 64'd0, 64'h55, 2'b00};
        v[13] = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd3,
                  5'd0, 5'd3, 64'd0, 64'h55, 2'b00};
        v[14] = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd3, 5'd10, 64'h55, 64'h1234, 2'b01};
        v[15] = '{2'b01, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'd0, 1'b0, 5'd0,
                  5'd31, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, 2'b10};

        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset rd_data", rd_data[63:0], 64'd0);
        chk("reset rd_busy", 64'(rd_busy), 64'd0);

        // Release; drive writes/reserves during clear, which must be ignored.
        reset   = 1'b0;
        wr_en   = 2'b11;
        wr_idx  = {5'd6, 5'd5};
        wr_data = {64'h6666, 64'h5555};
        rsv_en  = 1'b1;
        rsv_idx = 5'd5;
        rd_idx  = {5'd6, 5'd5};
        #1;
        wait_ready("init");
        idle();
        rd_idx = {5'd6, 5'd5};
        #1;
        chk("clear ignored wr idx5", rd_data[63:0], 64'd0);
        chk("clear ignored wr idx6", rd_data[127:64], 64'd0);
        chk("clear ignored rsv", 64'(rd_busy), 64'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wr_en   = v[i].we;
            wr_idx  = {v[i].wi1, v[i].wi0};
            wr_data = {v[i].wd1, v[i].wd0};
            rsv_en  = v[i].re;
            rsv_idx = v[i].ri;
            rd_idx  = {v[i].r1, v[i].r0};
            #1;
            chk($sformatf("v%0d rd0", i), rd_data[63:0],   v[i].e0);
            chk($sformatf("v%0d rd1", i), rd_data[127:64], v[i].e1);
            chk($sformatf("v%0d busy0", i), 64'(rd_busy[0]), 64'(v[i].eb[0]));
            chk($sformatf("v%0d busy1", i), 64'(rd_busy[1]), 64'(v[i].eb[1]));
        end

        // Reset in the middle of a clear restarts the count.
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midclear ready", 64'(ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        wait_ready("restart");
        rd_idx = {5'd10, 5'd3};
        #1;
        chk("post-clear idx3", rd_data[63:0], 64'd0);
        chk("post-clear idx10", rd_data[127:64], 64'd0);
        chk("post-clear busy", 64'(rd_busy), 64'd0);
        chk("post-clear ready", 64'(ready), 64'd1);

`ifdef REGFILE_PARITY_EN
        @(negedge clk);
        idle();
        wr_en   = 2'b01;
        wr_idx  = {5'd0, 5'd4};
        wr_data = {64'd0, 64'd1};
        @(negedge clk);
        idle();
        rd_idx = {5'd0, 5'd4};
        #1;
        chk("par clean read", 64'(par_err), 64'd0);
        force_flip = {1'b1, 5'd4};
        @(negedge clk);
        force_flip = '0;
        #1;
        chk("par flipped data", rd_data[63:0], 64'd1);
        chk("par flipped err", 64'(par_err), 64'd1);
        @(negedge clk);
        wr_en   = 2'b10;
        wr_idx  = {5'd4, 5'd0};
        wr_data = {64'd2, 64'd0};
        #1;
        chk("par bypass data", rd_data[63:0], 64'd2);
        chk("par bypass err", 64'(par_err), 64'd0);
        @(negedge clk);
        idle();
        rd_idx = {5'd0, 5'd4};
        #1;
        chk("par rewritten err", 64'(par_err), 64'd0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
